mouse_quadrature_gen: RTL and testbench

//  Converts MiSTer PS/2 mouse packets into trackball-style direction/clock signals
//  for the Centipede trackball input (trakball_i), one channel per axis.

---
 rtl/mouse_quadrature_gen.sv | 151 +++++++++++++++
 tb/tb_mouse_quadrature_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mouse_quadrature_gen.sv
// Purpose : turns PS/2 mouse packets into per-axis direction/step-clock pairs for a trackball input.
// Ports   : clk/reset, flip, mouse_speed, ps2_mouse packet bus -> h_dir/h_clk, v_dir/v_clk (all registered).
// Timing  : packet delta lands in the accumulator 1 cycle after detection; steps paced one per STEP_DIV cycles.
module mouse_quadrature_gen #(
  parameter int ACC_W    = 14,
  parameter int STEP_DIV = 1200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flip,
  input  logic [1:0]  mouse_speed,
  input  logic [24:0] ps2_mouse,
  output logic        h_dir,
  output logic        h_clk,
  output logic        v_dir,
  output logic        v_clk
);

  // Largest scaled delta is 256 * 8 = 2048, which needs 13 signed bits.
  localparam int DW = 13;
  // Working width wide enough that acc + delta - consume can never wrap before saturation.
  localparam int SW = ((ACC_W > DW) ? ACC_W : DW) + 2;
  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic signed [SW-1:0] ACC_MAX = SW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] FOUR    = SW'(4);

  // Packet detection
  logic tog_q;
  logic new_pkt;
  assign new_pkt = ps2_mouse[24] ^ tog_q;

  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

  logic signed [9:0] dx_raw;
  logic signed [9:0] dy_raw;
  // Y is negated so that "down" (mouse Y negative) accumulates as positive.
  assign dx_raw = {ps2_mouse[4], ps2_mouse[4], ps2_mouse[15:8]};
  assign dy_raw = -$signed({ps2_mouse[5], ps2_mouse[5], ps2_mouse[23:16]});

  // Speed is sampled with the packet, so a speed change only affects later packets.
  function automatic logic signed [DW-1:0] scale(input logic signed [9:0] d,
                                                  input logic [1:0] sp);
    logic signed [DW-1:0] e;
    e = {{(DW-10){d[9]}}, d};
    case (sp)
      2'b00:   scale = e <<< 2;
      2'b01:   scale = e <<< 3;
      2'b10:   scale = e;
      default: scale = e <<< 1;
    endcase
  endfunction

  logic                 pkt_vld;
  logic signed [DW-1:0] dx_q;
  logic signed [DW-1:0] dy_q;

  // Shared step prescaler
  logic [CW-1:0] cnt;
  logic          tick;

  // One axis: decide on dir update / toggle, then fold in delta and consumption together.
  function automatic void axis_next(input  logic signed [ACC_W-1:0] acc,
                                    input  logic                    dir,
                                    input  logic signed [DW-1:0]    delta,
                                    input  logic                    add,
                                    input  logic                    tck,
                                    input  logic                    flp,
                                    output logic signed [ACC_W-1:0] acc_n,
                                    output logic                    dir_n,
                                    output logic                    tgl);
    logic signed [SW-1:0] a;
    logic signed [SW-1:0] cons;
    logic signed [SW-1:0] sum;
    logic                 want;
    a     = SW'(acc);
    cons  = '0;
    dir_n = dir;
    tgl   = 1'b0;
    want  = (a > 0) ^ flp;
    if (tck && ((a >= FOUR) || (a <= -FOUR))) begin
      // A direction change costs one tick with no edge, giving the game a full
      // step period of direction setup before the next clock toggle.
      if (want != dir) begin
        dir_n = want;
      end else begin
        tgl  = 1'b1;
        cons = (a > 0) ? FOUR : -FOUR;
      end
    end
    sum = a + (add ? SW'(delta) : '0) - cons;
    if (sum > ACC_MAX)       acc_n = ACC_MAX[ACC_W-1:0];
    else if (sum < -ACC_MAX) acc_n = (-ACC_MAX);
    else                     acc_n = sum[ACC_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] h_acc;
  logic signed [ACC_W-1:0] v_acc;
  logic signed [ACC_W-1:0] h_acc_n;
  logic signed [ACC_W-1:0] v_acc_n;
  logic                    h_dir_n;
  logic                    v_dir_n;
  logic                    h_tgl;
  logic                    v_tgl;

  always_comb begin
    h_acc_n = h_acc;
    v_acc_n = v_acc;
    h_dir_n = h_dir;
    v_dir_n = v_dir;
    h_tgl   = 1'b0;
    v_tgl   = 1'b0;
    axis_next(h_acc, h_dir, dx_q, pkt_vld, tick, flip, h_acc_n, h_dir_n, h_tgl);
    axis_next(v_acc, v_dir, dy_q, pkt_vld, tick, flip, v_acc_n, v_dir_n, v_tgl);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q   <= 1'b0;
      pkt_vld <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      h_acc   <= '0;
      v_acc   <= '0;
      h_dir   <= 1'b0;
      v_dir   <= 1'b0;
      h_clk   <= 1'b0;
      v_clk   <= 1'b0;
    end else begin
      tog_q   <= ps2_mouse[24];
      pkt_vld <= new_pkt;
      if (new_pkt) begin
        dx_q <= scale(dx_raw, mouse_speed);
        dy_q <= scale(dy_raw, mouse_speed);
      end
      if (cnt == CW'(STEP_DIV - 1)) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
      // Tick is high during the cycle the count sits at 0 after wrapping.
      tick  <= (cnt == CW'(STEP_DIV - 1));
      h_acc <= h_acc_n;
      v_acc <= v_acc_n;
      h_dir <= h_dir_n;
      v_dir <= v_dir_n;
      if (h_tgl) h_clk <= ~h_clk;
      if (v_tgl) v_clk <= ~v_clk;
    end
  end

endmodule

// File: tb/tb_mouse_quadrature_gen.sv
// Directed bench for mouse_quadrature_gen with a short step period.
// Times are counted in clk cycles since reset release; the first tick acts at cycle SD+1.
module tb_mouse_quadrature_gen;
  localparam int SD = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flip = 1'b0;
  logic [1:0]  mouse_speed = 2'b00;
  logic [24:0] ps2_mouse = '0;
  logic        h_dir, h_clk, v_dir, v_clk;

  mouse_quadrature_gen #(.ACC_W(14), .STEP_DIV(SD)) dut (
    .clk(clk), .reset(reset), .flip(flip), .mouse_speed(mouse_speed),
    .ps2_mouse(ps2_mouse), .h_dir(h_dir), .h_clk(h_clk), .v_dir(v_dir), .v_clk(v_clk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  logic tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output activity monitor
  int h_cnt = 0, v_cnt = 0;
  int h_t[$], v_t[$], hd_t[$], vd_t[$];
  logic h_clk_p = 1'b0, v_clk_p = 1'b0, h_dir_p = 1'b0, v_dir_p = 1'b0;
  int h_base = 0, v_base = 0, hb = 0, vb = 0, hdb = 0, vdb = 0;

  always @(negedge clk) begin
    if (h_clk !== h_clk_p) begin h_cnt++; h_t.push_back(cyc - rel_cyc); end
    if (v_clk !== v_clk_p) begin v_cnt++; v_t.push_back(cyc - rel_cyc); end
    if (h_dir !== h_dir_p) hd_t.push_back(cyc - rel_cyc);
    if (v_dir !== v_dir_p) vd_t.push_back(cyc - rel_cyc);
    h_clk_p = h_clk; v_clk_p = v_clk; h_dir_p = h_dir; v_dir_p = v_dir;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic wait_until(input int r);
    while (cyc - rel_cyc < r) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic xs, input logic [7:0] xb, input logic ys, input logic [7:0] yb);
    tog = ~tog;
    ps2_mouse = {tog, yb, xb, 2'b00, ys, xs, 4'b0000};
  endtask

  task automatic do_reset();
    reset = 1'b1; ps2_mouse = '0; tog = 1'b0; flip = 1'b0; mouse_speed = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel_cyc = cyc;
    h_base = h_cnt; v_base = v_cnt;
    hb = h_t.size(); vb = v_t.size(); hdb = hd_t.size(); vdb = vd_t.size();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({h_dir, h_clk, v_dir, v_clk} !== 4'b0000) begin failures++; $display("FAIL reset_outputs got=%b exp=0000", {h_dir, h_clk, v_dir, v_clk}); end
    checks++; if ($signed(dut.h_acc) !== 14'sd0) begin failures++; $display("FAIL reset_h_acc got=%0d exp=0", $signed(dut.h_acc)); end
    do_reset();
    wait_until(10 * SD + 5);
    checks++; if (h_cnt - h_base !== 0) begin failures++; $display("FAIL idle_h_toggles got=%0d exp=0", h_cnt - h_base); end
    checks++; if (v_cnt - v_base !== 0) begin failures++; $display("FAIL idle_v_toggles got=%0d exp=0", v_cnt - v_base); end
    checks++; if ({h_dir, v_dir} !== 2'b00) begin failures++; $display("FAIL idle_dirs got=%b exp=00", {h_dir, v_dir}); end
    checks++; if (hd_t.size() - hdb + vd_t.size() - vdb !== 0) begin failures++; $display("FAIL idle_dir_changes got=%0d exp=0", hd_t.size() - hdb + vd_t.size() - vdb); end
  endtask

  task automatic test_basic_x();
    do_reset();
    wait_until(2); send(1'b0, 8'h03, 1'b0, 8'h00);       // +3 counts -> acc 12
    wait_until(SD + 11);
    checks++; if (h_dir !== 1'b1 || h_cnt - h_base !== 0) begin failures++; $display("FAIL x3_dir_setup dir=%b toggles=%0d exp dir=1 toggles=0", h_dir, h_cnt - h_base); end
    wait_until(4 * SD + 11);
    checks++; if (h_cnt - h_base !== 3) begin failures++; $display("FAIL x3_toggles got=%0d exp=3", h_cnt - h_base); end
    checks++; if ($signed(dut.h_acc) !== 14'sd0) begin failures++; $display("FAIL x3_acc got=%0d exp=0", $signed(dut.h_acc)); end
    checks++; if (v_cnt - v_base !== 0 || v_dir !== 1'b0) begin failures++; $display("FAIL x3_v_quiet toggles=%0d dir=%b exp 0/0", v_cnt - v_base, v_dir); end
    if (h_t.size() < hb + 3 || hd_t.size() < hdb + 1) begin
      checks++; failures++; $display("FAIL x3_timing missing events h=%0d d=%0d", h_t.size() - hb, hd_t.size() - hdb);
    end else begin
      checks++; if (hd_t[hdb] !== SD + 1) begin failures++; $display("FAIL x3_dir_time got=%0d exp=%0d", hd_t[hdb], SD + 1); end
      checks++; if (h_t[hb] !== 2 * SD + 1) begin failures++; $display("FAIL x3_first_edge got=%0d exp=%0d", h_t[hb], 2 * SD + 1); end
      checks++; if (h_t[hb+1] - h_t[hb] !== SD || h_t[hb+2] - h_t[hb+1] !== SD) begin failures++; $display("FAIL x3_spacing got=%0d,%0d exp=%0d", h_t[hb+1] - h_t[hb], h_t[hb+2] - h_t[hb+1], SD); end
    end
  endtask

  task automatic test_quarter_speed();
    do_reset();
    mouse_speed = 2'b10;
    for (int i = 0; i < 4; i++) begin wait_until(2 + 2 * i); send(1'b0, 8'h01, 1'b0, 8'h00); end
    wait_until(3 * SD + 11);
    checks++; if (h_cnt - h_base !== 1) begin failures++; $display("FAIL q4_toggles got=%0d exp=1", h_cnt - h_base); end
    checks++; if ($signed(dut.h_acc) !== 14'sd0) begin failures++; $display("FAIL q4_acc got=%0d exp=0", $signed(dut.h_acc)); end
    checks++; if (h_dir !== 1'b1) begin failures++; $display("FAIL q4_dir got=%b exp=1", h_dir); end
    wait_until(3 * SD + 12); send(1'b0, 8'h01, 1'b0, 8'h00);
    wait_until(6 * SD + 11);
    checks++; if (h_cnt - h_base !== 1) begin failures++; $display("FAIL q1_toggles got=%0d exp=1", h_cnt - h_base); end
    checks++; if ($signed(dut.h_acc) !== 14'sd1) begin failures++; $display("FAIL q1_residual got=%0d exp=1", $signed(dut.h_acc)); end
  endtask

  task automatic test_y_axis();
    do_reset();
    wait_until(2); send(1'b0, 8'h00, 1'b0, 8'h02);       // up 2 -> acc -8
    wait_until(3 * SD + 11);
    checks++; if (v_cnt - v_base !== 2) begin failures++; $display("FAIL yup_toggles got=%0d exp=2", v_cnt - v_base); end
    checks++; if (v_dir !== 1'b0) begin failures++; $display("FAIL yup_dir got=%b exp=0", v_dir); end
    checks++; if (h_cnt - h_base !== 0) begin failures++; $display("FAIL yup_h_quiet got=%0d exp=0", h_cnt - h_base); end
    wait_until(3 * SD + 12); send(1'b0, 8'h00, 1'b1, 8'hFE);  // down 2 -> acc +8
    wait_until(4 * SD + 11);
    checks++; if (v_dir !== 1'b1 || v_cnt - v_base !== 2) begin failures++; $display("FAIL ydn_dir_only dir=%b toggles=%0d exp 1/2", v_dir, v_cnt - v_base); end
    wait_until(6 * SD + 11);
    checks++; if (v_cnt - v_base !== 4) begin failures++; $display("FAIL ydn_toggles got=%0d exp=4", v_cnt - v_base); end
    checks++; if ($signed(dut.v_acc) !== 14'sd0) begin failures++; $display("FAIL ydn_acc got=%0d exp=0", $signed(dut.v_acc)); end
  endtask

  task automatic test_saturation();
    do_reset();
    mouse_speed = 2'b01;
    for (int i = 0; i < 8; i++) begin wait_until(2 + i); send(1'b1, 8'h00, 1'b0, 8'h00); end
    wait_until(15);
    checks++; if ($signed(dut.h_acc) !== -14'sd8191) begin failures++; $display("FAIL sat_acc got=%0d exp=-8191", $signed(dut.h_acc)); end
    wait_until(5 * SD + 11);
    checks++; if (h_cnt - h_base !== 5) begin failures++; $display("FAIL sat_toggles got=%0d exp=5", h_cnt - h_base); end
    checks++; if ($signed(dut.h_acc) !== -14'sd8171) begin failures++; $display("FAIL sat_drain got=%0d exp=-8171", $signed(dut.h_acc)); end
    checks++; if (h_dir !== 1'b0) begin failures++; $display("FAIL sat_dir got=%b exp=0", h_dir); end
  endtask

  task automatic test_flip_and_overlap();
    do_reset();
    flip = 1'b1;
    wait_until(2); send(1'b0, 8'h01, 1'b0, 8'h00);       // +4, flipped -> dir stays 0
    wait_until(SD + 11);
    checks++; if (h_dir !== 1'b0 || h_cnt - h_base !== 1) begin failures++; $display("FAIL flip_step dir=%b toggles=%0d exp 0/1", h_dir, h_cnt - h_base); end
    wait_until(SD + 12); send(1'b0, 8'h02, 1'b0, 8'h00);  // acc 8
    wait_until(3 * SD - 1); send(1'b0, 8'h03, 1'b0, 8'h00); // lands on the tick cycle
    wait_until(3 * SD + 5);
    checks++; if ($signed(dut.h_acc) !== 14'sd12) begin failures++; $display("FAIL overlap_acc got=%0d exp=12", $signed(dut.h_acc)); end
    checks++; if (h_cnt - h_base !== 3) begin failures++; $display("FAIL overlap_toggles got=%0d exp=3", h_cnt - h_base); end
    wait_until(3 * SD + 10);
    reset = 1'b1;
    #1;
    checks++; if (h_clk !== 1'b0 || h_dir !== 1'b0 || $signed(dut.h_acc) !== 14'sd0) begin failures++; $display("FAIL midreset clk=%b dir=%b acc=%0d exp 0/0/0", h_clk, h_dir, $signed(dut.h_acc)); end
    do_reset();
    wait_until(3 * SD + 11);
    checks++; if (h_cnt - h_base !== 0 || $signed(dut.h_acc) !== 14'sd0) begin failures++; $display("FAIL postreset toggles=%0d acc=%0d exp 0/0", h_cnt - h_base, $signed(dut.h_acc)); end
  endtask

  initial begin
    test_reset();
    test_basic_x();
    test_quarter_speed();
    test_y_axis();
    test_saturation();
    test_flip_and_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
